// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall bus width,
// stage indices and control FSM state encodings.
package pipe_hazard_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_mask_gen.sv
// Combinational highest-set-bit to thermometer stall mask, plus a one-hot
// bubble marker on the stage just above the highest held stage.
module stall_mask_gen
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int W = STALL_BUS_W
) (
    input  logic [W-1:0] eff,
    output logic [W-1:0] stall,
    output logic [W-1:0] bubble
);

    logic acc;

    always_comb begin
        acc    = 1'b0;
        stall  = '0;
        bubble = '0;
        // Running OR from the top stage down yields the thermometer directly.
        for (int i = W - 1; i >= 0; i--) begin
            acc      = acc | eff[i];
            stall[i] = acc;
        end
        for (int i = 1; i < W; i++) begin
            bubble[i] = stall[i-1] & ~stall[i];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble generation, registered flush and
// redirect, load-use one-bubble masking and a sticky stall watchdog.
// Optional performance counters are enabled by defining STALL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = STALL_BUS_W,
    parameter int PC_W       = 32,
    parameter int LOAD_STAGE = STG_ID,
    parameter int MAX_STALL  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  load_use_req,
    input  logic                  flush_req,
    input  logic [PC_W-1:0]       flush_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  flush,
    output logic [PC_W-1:0]       new_pc,
    output logic                  stall_timeout,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);

    localparam int LEN_W = $clog2(MAX_STALL + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_STALL);

    state_e                state;
    logic                  lu_mask;
    logic                  lu_hit;
    logic [NUM_STAGES-1:0] lu_vec;
    logic [NUM_STAGES-1:0] eff;
    logic [NUM_STAGES-1:0] stall_raw;
    logic [NUM_STAGES-1:0] bubble_raw;
    logic [LEN_W-1:0]      stall_len;

    assign lu_hit = load_use_req & ~lu_mask;

    always_comb begin
        lu_vec             = '0;
        lu_vec[LOAD_STAGE] = lu_hit;
    end

    assign eff = stall_req | lu_vec;

    stall_mask_gen #(
        .W(NUM_STAGES)
    ) u_stall_mask_gen (
        .eff   (eff),
        .stall (stall_raw),
        .bubble(bubble_raw)
    );

    // The flush cycle (and reset) overrides any hold so the redirect lands cleanly.
    assign flush  = (state == ST_FLUSH);
    assign stall  = (rst || flush) ? '0 : stall_raw;
    assign bubble = (rst || flush) ? '0 : bubble_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            lu_mask <= 1'b0;
            new_pc  <= '0;
        end else begin
            lu_mask <= lu_hit & ~flush;
            if (flush_req) begin
                state  <= ST_FLUSH;
                new_pc <= flush_pc;
            end else if (|eff) begin
                state <= ST_HOLD;
            end else begin
                state <= ST_RUN;
            end
        end
    end

    // Watchdog: consecutive-stall length saturates at MAX_STALL; the flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_len     <= '0;
            stall_timeout <= 1'b0;
        end else if (|stall) begin
            if (stall_len != LEN_MAX) begin
                stall_len <= stall_len + LEN_W'(1);
            end
            if (stall_len == LEN_MAX - LEN_W'(1)) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            stall_len <= '0;
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall[0]) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (MAX_STALL reduced to 8
// so the watchdog can be reached in a short run).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall_req = 6'b111111;
    logic        load_use_req = 1'b0;
    logic        flush_req = 1'b1;
    logic [31:0] flush_pc = 32'hDEAD_BEEF;
    logic [5:0]  stall;
    logic [5:0]  bubble;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    pipe_hazard_ctrl #(
        .NUM_STAGES(6),
        .PC_W      (32),
        .LOAD_STAGE(2),
        .MAX_STALL (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .load_use_req  (load_use_req),
        .flush_req     (flush_req),
        .flush_pc      (flush_pc),
        .stall         (stall),
        .bubble        (bubble),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  sr;
        logic        lu;
        logic        fr;
        logic [31:0] pc;
        logic [5:0]  st;
        logic [5:0]  bu;
        logic        fl;
        logic [31:0] npc;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned m_ps  = 0;
    int unsigned m_pf  = 0;

    function automatic vec_t mk(logic r, logic [5:0] sr, logic lu, logic fr, logic [31:0] pc,
                                logic [5:0] st, logic [5:0] bu, logic fl, logic [31:0] npc);
        vec_t v;
        v.rst = r; v.sr = sr; v.lu = lu; v.fr = fr; v.pc = pc;
        v.st = st; v.bu = bu; v.fl = fl; v.npc = npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge; outputs are then sampled on the falling edge.
    task automatic step(input logic r, input logic [5:0] sr, input logic lu,
                        input logic fr, input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst = r; stall_req = sr; load_use_req = lu; flush_req = fr; flush_pc = pc;
        @(negedge clk);
    endtask

    function automatic logic [31:0] perf_exp(input int unsigned model);
`ifdef STALL_PERF_EN
        return model;
`else
        return (model == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        // Reset with hostile inputs, then basic stalls, flush, load-use.
        tbl.push_back(mk(1, 6'b111111, 0, 1, 32'hDEAD_BEEF, 6'b000000, 6'b000000, 0, 32'h0));
        tbl.push_back(mk(1, 6'b111111, 0, 1, 32'hDEAD_BEEF, 6'b000000, 6'b000000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000100, 0, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000100, 0, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000100, 0, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b010100, 0, 0, 32'h0,         6'b011111, 6'b100000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b100000, 0, 0, 32'h0,         6'b111111, 6'b000000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000100, 0, 1, 32'hBFC00380,  6'b000111, 6'b001000, 0, 32'h0));
        tbl.push_back(mk(0, 6'b000100, 0, 0, 32'h0,         6'b000000, 6'b000000, 1, 32'hBFC00380));
        tbl.push_back(mk(0, 6'b000100, 0, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'hBFC00380));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'hBFC00380));
        tbl.push_back(mk(0, 6'b000000, 0, 1, 32'h11111111,  6'b000000, 6'b000000, 0, 32'hBFC00380));
        tbl.push_back(mk(0, 6'b000000, 0, 1, 32'h22222222,  6'b000000, 6'b000000, 1, 32'h11111111));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 1, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 1, 1, 32'h33333333,  6'b000111, 6'b001000, 0, 32'h22222222));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000000, 6'b000000, 1, 32'h33333333));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000111, 6'b001000, 0, 32'h33333333));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h33333333));
        tbl.push_back(mk(0, 6'b100000, 1, 0, 32'h0,         6'b111111, 6'b000000, 0, 32'h33333333));
        tbl.push_back(mk(0, 6'b000000, 1, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h33333333));
        tbl.push_back(mk(0, 6'b000000, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h33333333));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sr, tbl[i].lu, tbl[i].fr, tbl[i].pc);
            chk($sformatf("v%0d.stall", i),   {26'd0, stall},  {26'd0, tbl[i].st});
            chk($sformatf("v%0d.bubble", i),  {26'd0, bubble}, {26'd0, tbl[i].bu});
            chk($sformatf("v%0d.flush", i),   {31'd0, flush},  {31'd0, tbl[i].fl});
            chk($sformatf("v%0d.new_pc", i),  new_pc,          tbl[i].npc);
            chk($sformatf("v%0d.timeout", i), {31'd0, stall_timeout}, 32'd0);
            if (tbl[i].rst) begin
                chk($sformatf("v%0d.perf_stall", i), perf_stall_cnt, 32'd0);
                chk($sformatf("v%0d.perf_flush", i), perf_flush_cnt, 32'd0);
            end
            if (tbl[i].st[0] && !tbl[i].rst) m_ps++;
            if (tbl[i].fl && !tbl[i].rst)    m_pf++;
        end
        chk("tbl.perf_stall", perf_stall_cnt, perf_exp(m_ps));
        chk("tbl.perf_flush", perf_flush_cnt, perf_exp(m_pf));

        // Watchdog must restart after an idle gap: 7 stall, 1 idle, 7 stall.
        for (int j = 0; j < 15; j++) begin
            if (j == 7) step(0, 6'b000000, 0, 0, 32'h0);
            else        step(0, 6'b000001, 0, 0, 32'h0);
            chk($sformatf("gap%0d.timeout", j), {31'd0, stall_timeout}, 32'd0);
        end
        step(0, 6'b000000, 0, 0, 32'h0);
        chk("gap.timeout_after", {31'd0, stall_timeout}, 32'd0);

        // Fresh reset, then 10 consecutive PC-stage stalls trip the watchdog.
        step(1, 6'b000000, 0, 0, 32'h0);
        chk("wd.rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("wd.rst_timeout", {31'd0, stall_timeout}, 32'd0);
        for (int j = 1; j <= 10; j++) begin
            step(0, 6'b000001, 0, 0, 32'h0);
            chk($sformatf("wd%0d.stall", j),  {26'd0, stall},  32'h01);
            chk($sformatf("wd%0d.bubble", j), {26'd0, bubble}, 32'h02);
            chk($sformatf("wd%0d.timeout", j), {31'd0, stall_timeout}, (j >= 9) ? 32'd1 : 32'd0);
        end
        for (int j = 0; j < 3; j++) begin
            step(0, 6'b000000, 0, 0, 32'h0);
            chk($sformatf("wd.rel%0d.stall", j),   {26'd0, stall}, 32'd0);
            chk($sformatf("wd.rel%0d.timeout", j), {31'd0, stall_timeout}, 32'd1);
        end
        chk("wd.perf_stall", perf_stall_cnt, perf_exp(10));
        chk("wd.perf_flush", perf_flush_cnt, perf_exp(0));

        step(1, 6'b000000, 0, 0, 32'h0);
        step(0, 6'b000000, 0, 0, 32'h0);
        chk("wd.cleared_by_rst", {31'd0, stall_timeout}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
